// File: rtl/qa_drv_hc_req_buffer.sv
// FWFT request buffer for the host-channel almost-full loop; deq_data is combinational from the head (0-cycle), almostfull registered.
// Backpressure: almostfull asserts with ALMOST_FULL_SLACK free entries left; enqueues beyond DEPTH are dropped and flagged in overflow.
module qa_drv_hc_req_buffer #(
  parameter int DATA_WIDTH        = 64,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_SLACK = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enq_en,
  input  logic [DATA_WIDTH-1:0]      enq_data,
  input  logic                       deq_en,
  output logic [DATA_WIDTH-1:0]      deq_data,
  output logic                       not_empty,
  output logic                       almostfull,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C     = PW'(DEPTH);
  localparam logic [PW-1:0] AF_THRESH_C = PW'(DEPTH - ALMOST_FULL_SLACK);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          almostfull_q, almostfull_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          enq_acc, deq_acc;
  logic [PW-1:0] count_cur, count_d;

  // Pointers wrap modulo 2*DEPTH, so their difference is the occupancy 0..DEPTH.
  assign count_cur = wr_ptr_q - rd_ptr_q;

  always_comb begin
    deq_acc      = deq_en && (count_cur != '0);
    enq_acc      = enq_en && ((count_cur < DEPTH_C) || deq_acc);
    wr_ptr_d     = wr_ptr_q + PW'(enq_acc);
    rd_ptr_d     = rd_ptr_q + PW'(deq_acc);
    count_d      = count_cur + PW'(enq_acc) - PW'(deq_acc);
    almostfull_d = (count_d >= AF_THRESH_C);
    overflow_d   = overflow_q  || (enq_en && !enq_acc);
    underflow_d  = underflow_q || (deq_en && !deq_acc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      almostfull_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      almostfull_q <= almostfull_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Contents survive reset; only the pointers define what is logically stored.
  always_ff @(posedge clk) begin
    if (enq_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= enq_data;
    end
  end

  assign deq_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign not_empty  = (count_cur != '0);
  assign count      = count_cur;
  assign almostfull = almostfull_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_qa_drv_hc_req_buffer.sv
// Scoreboard bench for qa_drv_hc_req_buffer: the driver keeps a queue-level model, a negedge monitor
// pops expected words and compares every visible output.
module tb_qa_drv_hc_req_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int SLACK = 4;

  logic          clk;
  logic          reset_n;
  logic          enq_en;
  logic [DW-1:0] enq_data;
  logic          deq_en;
  logic [DW-1:0] deq_data;
  logic          not_empty;
  logic          almostfull;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  qa_drv_hc_req_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_SLACK(SLACK)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .enq_en(enq_en), .enq_data(enq_data), .deq_en(deq_en),
    .deq_data(deq_data), .not_empty(not_empty), .almostfull(almostfull),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  int            mdl_cnt = 0;
  bit            exp_af  = 0;
  bit            exp_ovf = 0;
  bit            exp_unf = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_cnt = 0;
    exp_af  = 0;
    exp_ovf = 0;
    exp_unf = 0;
  endtask

  // Called at posedge+1; drives one cycle of stimulus and advances the model at the edge.
  task automatic cycle(input bit e, input logic [DW-1:0] d, input bit q);
    bit deq_ok, enq_ok;
    enq_en   = e;
    enq_data = d;
    deq_en   = q;
    @(posedge clk);
    deq_ok = q && (mdl_cnt > 0);
    enq_ok = e && (mdl_cnt < DEPTH || deq_ok);
    if (e && !enq_ok) exp_ovf = 1;
    if (q && !deq_ok) exp_unf = 1;
    if (enq_ok) exp_q.push_back(d);
    mdl_cnt = mdl_cnt + (enq_ok ? 1 : 0) - (deq_ok ? 1 : 0);
    exp_af  = (mdl_cnt >= DEPTH - SLACK);
    #1;
    enq_en = 0;
    deq_en = 0;
  endtask

  // Monitor: compares outputs mid-cycle and consumes the head whenever a pop is presented.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("count", DW'(count), DW'(mdl_cnt));
      chk("not_empty", DW'(not_empty), DW'(mdl_cnt != 0));
      chk("almostfull", DW'(almostfull), DW'(exp_af));
      chk("overflow", DW'(overflow), DW'(exp_ovf));
      chk("underflow", DW'(underflow), DW'(exp_unf));
      if (deq_en && not_empty) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deq_unexpected: got %0h, expected no data", deq_data);
        end else begin
          chk("deq_data", deq_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] data;
    bit af_reg, af_smp;
    int pe, pd;

    reset_n  = 1;
    enq_en   = 0;
    deq_en   = 0;
    enq_data = '0;
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("rst_count", DW'(count), 0);
    chk("rst_not_empty", DW'(not_empty), 0);
    chk("rst_almostfull", DW'(almostfull), 0);
    chk("rst_overflow", DW'(overflow), 0);
    chk("rst_underflow", DW'(underflow), 0);
    #30 reset_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) cycle(0, '0, 0);

    // Requester with a one-cycle register on almostfull.
    data   = 0;
    af_reg = 0;
    for (int i = 0; i < 20; i++) begin
      af_smp = almostfull;
      if (af_reg) break;
      cycle(1, data, 0);
      data++;
      af_reg = af_smp;
      if (data == 11) chk("af_before_12th", DW'(almostfull), 0);
      if (data == 12) chk("af_at_12th", DW'(almostfull), 1);
    end
    chk("req_count_le15", DW'(count <= 15), 1);
    chk("req_no_overflow", DW'(overflow), 0);

    for (int i = 0; i < 20 && mdl_cnt < DEPTH; i++) begin
      cycle(1, data, 0);
      data++;
    end
    cycle(1, data, 0);
    chk("full_overflow", DW'(overflow), 1);
    chk("full_count", DW'(count), 16);
    cycle(1, data, 1);
    data++;
    chk("full_enq_deq_count", DW'(count), 16);
    chk("full_new_head", deq_data, 64'h1);

    for (int i = 0; i < 20 && mdl_cnt > 0; i++) begin
      cycle(0, '0, 1);
      if (mdl_cnt == 12) chk("af_at_12", DW'(almostfull), 1);
      if (mdl_cnt == 11) chk("af_fall_11", DW'(almostfull), 0);
    end
    chk("drained_not_empty", DW'(not_empty), 0);
    cycle(0, '0, 1);
    chk("empty_underflow", DW'(underflow), 1);

    for (int i = 0; i < 40; i++) begin
      if ((i % 5) < 3) begin
        cycle(1, data, 0);
        data++;
      end else begin
        cycle(0, '0, 1);
      end
    end

    for (int seg = 0; seg < 3; seg++) begin
      pe = (seg == 0) ? 80 : (seg == 1) ? 30 : 55;
      pd = (seg == 0) ? 30 : (seg == 1) ? 80 : 55;
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(99) < pe, {$urandom, $urandom}, $urandom_range(99) < pd);
      end
    end

    for (int i = 0; i < 20 && mdl_cnt > 0; i++) cycle(0, '0, 1);
    for (int i = 0; i < 9; i++) cycle(1, DW'(i + 32'h100), 0);
    chk("pre_reset_count", DW'(count), 9);
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("mid_rst_count", DW'(count), 0);
    chk("mid_rst_not_empty", DW'(not_empty), 0);
    chk("mid_rst_almostfull", DW'(almostfull), 0);
    chk("mid_rst_overflow", DW'(overflow), 0);
    chk("mid_rst_underflow", DW'(underflow), 0);
    #12 reset_n = 1;
    @(posedge clk);
    #1;
    cycle(1, 64'hA5, 0);
    chk("post_rst_data", deq_data, 64'hA5);
    chk("post_rst_count", DW'(count), 1);
    cycle(0, '0, 1);
    cycle(0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
